// File: rtl/mux_rr_arbiter_8_pkg.sv
// Shared types, sizes and the round-robin search helper for the 8-way
// arbitrated mux.
package mux_rr_arbiter_8_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First set bit of req in the order ptr, ptr+1, ... ptr+7 (mod 8).
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                     input logic [SEL_W-1:0] ptr);
      pick_t            p;
      logic [SEL_W-1:0] k;
      p = '0;
      // Walk from the farthest offset down so the nearest hit is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = ptr + SEL_W'(i);
         if (req[k]) begin
            p.found = 1'b1;
            p.idx   = k;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_8_if.sv
// Request/data bundle from the eight requesters and the grant/select/output
// signals returned by the arbiter.
interface mux_rr_arbiter_8_if;
   import mux_rr_arbiter_8_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] I;
   logic [N_REQ-1:0] gnt;
   logic             S2;
   logic             S1;
   logic             S0;
   logic             valid;
   logic             Y;

   modport master (output req, output I,
                   input gnt, input S2, input S1, input S0, input valid, input Y);
   modport slave  (input req, input I,
                   output gnt, output S2, output S1, output S0, output valid, output Y);
endinterface

// File: rtl/mux_8_to_1.sv
// Plain 8:1 multiplexer with discrete select lines; S2 is the MSB.
module mux_8_to_1 (
   input  logic [7:0] I,
   input  logic       S2,
   input  logic       S1,
   input  logic       S0,
   output logic       Y
);
   assign Y = I[{S2, S1, S0}];
endmodule

// File: rtl/mux_rr_arbiter_8.sv
// Round-robin arbiter owning a shared 8:1 mux; an owner keeps the mux for at
// most MAX_HOLD consecutive cycles.
module mux_rr_arbiter_8
   import mux_rr_arbiter_8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mux_rr_arbiter_8_if.slave  bus
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [SEL_W-1:0] sel, sel_nxt;
   logic [3:0]       hold_cnt, hold_cnt_nxt;
   logic [N_REQ-1:0] gnt, gnt_nxt;
   logic             valid, valid_nxt;

   logic             owner_req;
   logic             release_now;
   logic [N_REQ-1:0] others;
   pick_t            pick_all, pick_other;
   logic             do_grant;
   logic [SEL_W-1:0] grant_idx;
   logic             mux_y;

   assign owner_req   = bus.req[sel];
   assign others      = bus.req & ~(N_REQ'(1) << sel);
   assign release_now = !owner_req || (hold_cnt == HOLD_LAST);
   assign pick_all    = rr_pick(bus.req, ptr);
   assign pick_other  = rr_pick(others, ptr);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      sel_nxt      = sel;
      hold_cnt_nxt = hold_cnt;
      gnt_nxt      = gnt;
      valid_nxt    = valid;
      do_grant     = 1'b0;
      grant_idx    = sel;

      case (state)
         IDLE: begin
            if (pick_all.found) begin
               do_grant  = 1'b1;
               grant_idx = pick_all.idx;
            end
         end
         GRANT: begin
            if (!release_now) begin
               hold_cnt_nxt = hold_cnt + 4'd1;
            end else if (pick_other.found) begin
               do_grant  = 1'b1;
               grant_idx = pick_other.idx;
            end else if (owner_req) begin
               do_grant  = 1'b1;
               grant_idx = sel;
            end else begin
               // Select lines keep their last value while idle.
               state_nxt = IDLE;
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (do_grant) begin
         state_nxt    = GRANT;
         gnt_nxt      = N_REQ'(1) << grant_idx;
         sel_nxt      = grant_idx;
         valid_nxt    = 1'b1;
         hold_cnt_nxt = '0;
         ptr_nxt      = grant_idx + 3'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         sel      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         sel      <= sel_nxt;
         hold_cnt <= hold_cnt_nxt;
         gnt      <= gnt_nxt;
         valid    <= valid_nxt;
      end
   end

   mux_8_to_1 u_mux (
      .I  (bus.I),
      .S2 (sel[2]),
      .S1 (sel[1]),
      .S0 (sel[0]),
      .Y  (mux_y)
   );

   assign bus.gnt   = gnt;
   assign bus.S2    = sel[2];
   assign bus.S1    = sel[1];
   assign bus.S0    = sel[0];
   assign bus.valid = valid;
   assign bus.Y     = valid & mux_y;

endmodule
